// File: rtl/drv_audio_i2s_rx_pkg.sv
// Shared audio types for the codec serial interfaces.
package pkg_audio;

  localparam int unsigned p_audio_width = 16;

  typedef logic [p_audio_width-1:0] t_sample;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } t_chan;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    HOLD
  } t_i2s_rx_st;

endpackage

// File: rtl/drv_audio_i2s_rx_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with rising- or any-edge strobe
// taken against the registered previous synchronised value.
module drv_audio_i2s_sync #(
  parameter int unsigned p_stages   = 2,
  parameter bit          p_any_edge = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_edge
);

  logic [p_stages-1:0] chain_q, chain_d;
  logic                prev_q, prev_d;

  always_comb begin
    chain_d = {chain_q[p_stages-2:0], i_d};
    prev_d  = chain_q[p_stages-1];
    o_q     = chain_q[p_stages-1];
    o_edge  = p_any_edge ? (chain_q[p_stages-1] ^ prev_q)
                         : (chain_q[p_stages-1] & ~prev_q);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

endmodule

// File: rtl/drv_audio_i2s_rx.sv
// I2S receiver: codec-mastered BCLK/LRCK/DAT into {left,right} pairs with a one-cycle strobe.
// Define DRV_AUDIO_I2S_RX_LJ_EN for left-justified framing (no 1-bit delay, LRCK=1 is left).
module drv_audio_i2s_rx
  import pkg_audio::*;
#(
  parameter int unsigned p_width       = p_audio_width,
  parameter int unsigned p_sync_stages = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_bclk,
  input  logic                    i_lrck,
  input  logic                    i_dat,
  output logic [1:0][p_width-1:0] o_dat,
  output logic                    o_req,
  output logic                    o_err
);

`ifdef DRV_AUDIO_I2S_RX_LJ_EN
  localparam logic c_lj = 1'b1;
`else
  localparam logic c_lj = 1'b0;
`endif

  localparam int unsigned     c_cw   = (p_width > 1) ? $clog2(p_width) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(p_width - 1);

  logic bclk_s_unused, bclk_rise;
  logic lrck_s, lrck_chg;
  logic dat_s, dat_edge_unused;

  drv_audio_i2s_sync #(.p_stages(p_sync_stages), .p_any_edge(1'b0)) u_sync_bclk (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_bclk), .o_q(bclk_s_unused), .o_edge(bclk_rise)
  );
  drv_audio_i2s_sync #(.p_stages(p_sync_stages), .p_any_edge(1'b1)) u_sync_lrck (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_lrck), .o_q(lrck_s), .o_edge(lrck_chg)
  );
  drv_audio_i2s_sync #(.p_stages(p_sync_stages), .p_any_edge(1'b0)) u_sync_dat (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_dat), .o_q(dat_s), .o_edge(dat_edge_unused)
  );

  t_i2s_rx_st                state_q, state_d;
  logic [c_cw-1:0]           cnt_q, cnt_d;
  logic [p_width-1:0]        shreg_q, shreg_d;
  t_chan                     chan_q, chan_d;
  logic                      last_q, last_d;
  logic                      lval_q, lval_d;
  logic [p_width-1:0]        left_q, left_d, right_q, right_d;
  logic                      pair_q, pair_d;
  logic [1:0][p_width-1:0]   o_dat_q, o_dat_d;
  logic                      o_req_q, o_req_d, o_err_q, o_err_d;
  logic [p_width-1:0]        word;
  t_chan                     lr_chan;
  logic                      word_done, legit_chg;
  t_i2s_rx_st                restart_st;

  always_comb begin
    word       = (shreg_q << 1) | p_width'(dat_s);
    lr_chan    = t_chan'(lrck_s ^ c_lj);
    word_done  = (cnt_q == c_last);
    // In I2S an LRCK change one bit before the end is normal: the final bit is the delay slot
    legit_chg  = !c_lj && word_done;
    restart_st = c_lj ? SHIFT : SKIP;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HOLD: if (lrck_chg) state_d = restart_st;
      SKIP:       if (bclk_rise) state_d = SHIFT;
      SHIFT: begin
        if (bclk_rise) begin
          if (word_done) state_d = last_q ? SHIFT : HOLD;
        end else if (lrck_chg && !legit_chg) begin
          state_d = restart_st;
        end
      end
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    chan_d  = chan_q;
    last_d  = last_q;
    lval_d  = lval_q;
    left_d  = left_q;
    right_d = right_q;
    pair_d  = 1'b0;
    o_err_d = 1'b0;
    o_req_d = pair_q;
    o_dat_d = pair_q ? {right_q, left_q} : o_dat_q;
    case (state_q)
      IDLE, HOLD: begin
        if (lrck_chg) begin
          cnt_d  = '0;
          chan_d = lr_chan;
          last_d = 1'b0;
        end
      end
      SKIP: begin
        if (bclk_rise) begin
          cnt_d  = '0;
          chan_d = lr_chan;
        end
      end
      SHIFT: begin
        if (bclk_rise) begin
          shreg_d = word;
          if (word_done) begin
            if (chan_q == CH_LEFT) begin
              left_d = word;
              lval_d = 1'b1;
            end else begin
              if (lval_q) begin
                right_d = word;
                pair_d  = 1'b1;
              end
              lval_d = 1'b0;
            end
            // The bit just taken doubled as the next word's delay slot
            if (last_q) begin
              cnt_d  = '0;
              chan_d = lr_chan;
              last_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (lrck_chg) begin
          if (legit_chg) begin
            last_d = 1'b1;
          end else begin
            o_err_d = 1'b1;
            lval_d  = 1'b0;
            cnt_d   = '0;
            chan_d  = lr_chan;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      chan_q  <= CH_LEFT;
      last_q  <= 1'b0;
      lval_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      pair_q  <= 1'b0;
      o_dat_q <= '0;
      o_req_q <= 1'b0;
      o_err_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
      lval_q  <= lval_d;
      left_q  <= left_d;
      right_q <= right_d;
      pair_q  <= pair_d;
      o_dat_q <= o_dat_d;
      o_req_q <= o_req_d;
      o_err_q <= o_err_d;
    end
  end

  assign o_dat = o_dat_q;
  assign o_req = o_req_q;
  assign o_err = o_err_q;

endmodule

// File: tb/tb_drv_audio_i2s_rx.sv
// Directed bench for drv_audio_i2s_rx; build with DRV_AUDIO_I2S_RX_LJ_EN for the left-justified variant.
module tb_drv_audio_i2s_rx;

  localparam int unsigned P_W    = 16;
  localparam int unsigned P_SYNC = 2;

  logic                i_clk  = 1'b0;
  logic                i_rst  = 1'b0;
  logic                i_bclk = 1'b0;
  logic                i_lrck = 1'b0;
  logic                i_dat  = 1'b0;
  logic [1:0][P_W-1:0] o_dat;
  logic                o_req;
  logic                o_err;

  drv_audio_i2s_rx #(.p_width(P_W), .p_sync_stages(P_SYNC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bclk(i_bclk), .i_lrck(i_lrck), .i_dat(i_dat),
    .o_dat(o_dat), .o_req(o_req), .o_err(o_err)
  );

  always #10 i_clk = ~i_clk;

  int   tests = 0, fails = 0;
  int   cyc = 0, req_cnt = 0, err_cnt = 0, req_cyc = 0;
  int   rise_cyc = 0, lsb_rise = 0, hp = 8;
  int   r0, e0;
  logic carry = 1'b0;
  bit   lj_mode;
  logic [15:0] lq[$], rq[$];
  logic [15:0] exp_l, exp_r;

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    if (o_req) begin
      req_cnt++;
      req_cyc = cyc;
      lq.push_back(o_dat[0]);
      rq.push_back(o_dat[1]);
    end
    if (o_err) err_cnt++;
    assert (!(o_req && o_err)) else begin
      fails++;
      $error("FAIL req_err_overlap: observed req=%0b err=%0b required not both", o_req, o_err);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one BCLK period: data/LRCK change on the falling edge, receiver samples on the rise
  task automatic bit_out(input logic lr, input logic d);
    @(negedge i_clk);
    i_bclk = 1'b0;
    i_lrck = lr;
    i_dat  = d;
    repeat (hp) @(negedge i_clk);
    i_bclk   = 1'b1;
    rise_cyc = cyc;
    repeat (hp - 1) @(negedge i_clk);
  endtask

  task automatic send_part(input logic lr, input logic [15:0] w, input int nbits,
                           input int k0, input int k1);
    logic d;
    for (int k = k0; k < k1; k++) begin
      if (lj_mode) d = (k < 16) ? w[15-k] : 1'b0;
      else         d = (k == 0) ? carry : ((k <= 16) ? w[16-k] : 1'b0);
      bit_out(lr, d);
      if (!lj_mode && k == 16) lsb_rise = rise_cyc;
    end
    if (k1 == nbits) carry = (!lj_mode && nbits == 16) ? w[0] : 1'b0;
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits);
    send_part(lr, w, nbits, 0, nbits);
  endtask

  initial begin
`ifdef DRV_AUDIO_I2S_RX_LJ_EN
    lj_mode = 1'b1;
`else
    lj_mode = 1'b0;
`endif
    // reset with toggling inputs
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      i_bclk = i[0];
      i_dat  = i[1];
      i_lrck = i[2];
      @(negedge i_clk);
      chk("rst_dat", o_dat, 32'h0);
      chk("rst_req", {31'b0, o_req}, 32'h0);
      chk("rst_err", {31'b0, o_err}, 32'h0);
    end
    @(negedge i_clk);
    i_bclk = 1'b0;
    i_lrck = 1'b0;
    i_dat  = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (6) @(negedge i_clk);
    chk("post_rst_dat", o_dat, 32'h0);

    if (lj_mode) begin
      send_slot(1'b1, 16'h00FF, 32);
      send_slot(1'b0, 16'hFF00, 32);
      chk("lj_req", req_cnt, 1);
      chk("lj_left", o_dat[0], 32'h00FF);
      chk("lj_right", o_dat[1], 32'hFF00);
      chk("lj_err", err_cnt, 0);
      send_slot(1'b1, 16'h1357, 32);
      send_slot(1'b0, 16'h2468, 32);
      chk("lj_req2", req_cnt, 2);
      chk("lj_left2", o_dat[0], 32'h1357);
      chk("lj_right2", o_dat[1], 32'h2468);
      chk("lj_err2", err_cnt, 0);
    end else begin
      // warm-up frame: right word arrives with no left -> dropped
      send_slot(1'b0, 16'h1111, 32);
      send_slot(1'b1, 16'h2222, 32);
      chk("warmup_no_req", req_cnt, 0);
      send_slot(1'b0, 16'h1234, 32);
      send_slot(1'b1, 16'hABCD, 32);
      chk("frame_req", req_cnt, 1);
      chk("frame_left", o_dat[0], 32'h1234);
      chk("frame_right", o_dat[1], 32'hABCD);
      chk("frame_latency", req_cyc - lsb_rise, P_SYNC + 2);
      chk("frame_err", err_cnt, 0);
      send_slot(1'b0, 16'h0F0F, 32);
      chk("hold_left", o_dat[0], 32'h1234);
      chk("hold_right", o_dat[1], 32'hABCD);
      chk("hold_req", req_cnt, 1);

      // reset mid right word, resume mid-word
      send_part(1'b1, 16'h5A5A, 32, 0, 8);
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (3) @(negedge i_clk);
      chk("midrst_dat", o_dat, 32'h0);
      chk("midrst_req", {31'b0, o_req}, 32'h0);
      i_rst = 1'b1;
      r0 = req_cnt;
      send_part(1'b1, 16'h5A5A, 32, 8, 14);
      chk("partial_no_req", req_cnt - r0, 0);
      send_slot(1'b0, 16'h8000, 32);
      send_slot(1'b1, 16'h7FFF, 32);
      chk("resume_req", req_cnt - r0, 1);
      chk("resume_left", o_dat[0], 32'h8000);
      chk("resume_right", o_dat[1], 32'h7FFF);

      // left word cut after 9 bits
      r0 = req_cnt;
      e0 = err_cnt;
      send_slot(1'b0, 16'h1357, 10);
      send_slot(1'b1, 16'h2468, 32);
      chk("trunc_err", err_cnt - e0, 1);
      chk("trunc_no_req", req_cnt - r0, 0);
      send_slot(1'b0, 16'hCAFE, 32);
      send_slot(1'b1, 16'hBEEF, 32);
      chk("after_trunc_req", req_cnt - r0, 1);
      chk("after_trunc_left", o_dat[0], 32'hCAFE);
      chk("after_trunc_right", o_dat[1], 32'hBEEF);
      chk("after_trunc_err", err_cnt - e0, 1);

      // back-to-back 16-bit slots at 8x oversampling
      hp = 4;
      lq.delete();
      rq.delete();
      r0 = req_cnt;
      e0 = err_cnt;
      for (int i = 0; i < 100; i++) begin
        send_slot(1'b0, 16'(i * 257 + 3), 16);
        send_slot(1'b1, 16'(32'hFFFF - i * 3), 16);
      end
      send_slot(1'b0, 16'h0000, 16);
      repeat (8) @(negedge i_clk);
      chk("stream_req", req_cnt - r0, 100);
      chk("stream_err", err_cnt - e0, 0);
      for (int i = 0; i < 100 && i < lq.size(); i++) begin
        exp_l = 16'(i * 257 + 3);
        exp_r = 16'(32'hFFFF - i * 3);
        chk("stream_left", lq[i], exp_l);
        chk("stream_right", rq[i], exp_r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
